fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Control core of the synchronous FIFO: sequences the write/read pointers, RAM enables, occupancy count and status flags around a 2^K-deep, 1-cycle-read-latency dual-port RAM.
- Supports standard mode and first-word-fall-through (FWFT) mode.
- Sits between the user push/pop interface and the FIFO RAM; holds no data itself.

Parameters:
- fwft, 1, 1 = FWFT mode (RAM read register acts as output stage); 0 = standard mode (data valid cycle after pop).
- K, 4, address width; DEPTH = 2^K.
- AF_LVL, 12, almost_full asserted when count >= AF_LVL.
- AE_LVL, 2, almost_empty asserted when count <= AE_LVL.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  1  push request.
- rd_req  in  1  pop request (FWFT: acknowledge of presented word).
- clr_err  in  1  synchronous clear of overflow/underflow.
- ram_we  out  1  RAM write enable (= accepted push).
- ram_waddr  out  K  RAM write address.
- ram_re  out  1  RAM read enable.
- ram_raddr  out  K  RAM read address.
- dout_valid  out  1  RAM read data valid this cycle.
- full  out  1  count == DEPTH.
- empty  out  1  no word available to pop.
- almost_full  out  1  count >= AF_LVL.
- almost_empty  out  1  count <= AE_LVL.
- count  out  K+1  total words held (RAM plus FWFT output stage).
- overflow  out  1  sticky: push while full.
- underflow  out  1  sticky: pop while empty.

Behaviour:
- Reset (async, rst_n=0): pointers 0, count 0, dout_valid 0, overflow/underflow 0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Mid-operation reset discards all contents immediately.
- push_ok = wr_req & !full.
  - ram_we = push_ok (combinational); ram_waddr = wptr.
  - wptr += 1 on push_ok, wraps DEPTH-1 -> 0.
  - Full blocks the write even when a pop occurs in the same cycle.
- pop_ok = rd_req & !empty.
- count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither. Never exceeds DEPTH, never below 0.
- mem_cnt = count - (fwft ? dout_valid : 0): words still in RAM, not yet fetched.
- Standard mode (fwft=0):
  - empty = (count==0).
  - ram_re = pop_ok; ram_raddr = rptr; rptr += 1 on ram_re.
  - dout_valid registered = ram_re of previous cycle (1-cycle read latency).
- FWFT mode (fwft=1):
  - empty = !dout_valid.
  - ram_re = (mem_cnt != 0) & (!dout_valid | pop_ok); rptr += 1 on ram_re.
  - dout_valid <= ram_re | (dout_valid & !pop_ok).
  - Word written at edge t is presented (dout_valid=1) after edge t+2 when the FIFO was empty.
  - Back-to-back pops sustain one word per cycle with no bubble.
- Push and pop in the same cycle while empty:
  - The pop is rejected and underflow is set; the push is accepted.
  - FWFT: the word appears 2 cycles later.
- Flags are registered or derived only from registered count/dout_valid; no combinational path from wr_req/rd_req to full/empty.
- Error flags:
  - overflow <= 1 on wr_req & full; underflow <= 1 on rd_req & empty.
  - clr_err clears both; a simultaneous error event wins over clr_err.
- Pointer arithmetic is modulo 2^K; count is K+1 bits.

Decomposition:
- Shared package fifo_pkg:
  - DEPTH derivation from K.
  - Mode constants FWFT_ON/FWFT_OFF.
  - Default AF/AE levels.
- Sub-module fifo_ptr(K): enable-driven wrapping binary pointer with async active-low reset, instanced twice (wptr, rptr).
- Flag/count logic and FWFT output-stage control stay in fifo_ctrl.

Test Plan:
- Reset then 16 pushes (K=4, fwft=0) -> ram_waddr 0..15; full=1 after 16th edge; count=16; almost_full rises at count 12.
- 17th push while full -> ram_we=0, overflow=1, count stays 16; clr_err -> overflow=0.
- fwft=1, single push at edge t -> ram_re high in cycle t+1; dout_valid=1 after t+2; empty=0; count=1.
- fwft=1, 8 words queued, rd_req held 8 cycles -> 8 consecutive dout_valid cycles, raddr 0..7, empty=1 after last pop, count=0.
- Simultaneous push+pop at count=5 for 20 cycles -> count stays 5; pointers wrap 15->0 with no flag glitch.
- rst_n low mid-stream at count=9 -> asynchronously count=0, empty=1, dout_valid=0, pointers 0; a pop before any push -> underflow=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO control core: mode selectors,
// default geometry and threshold levels.
package fifo_pkg;

    localparam bit FWFT_ON  = 1'b1;
    localparam bit FWFT_OFF = 1'b0;

    localparam int K_DEF      = 4;
    localparam int AF_LVL_DEF = 12;
    localparam int AE_LVL_DEF = 2;

    function automatic int depth_of(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Enable-driven binary pointer that wraps modulo 2^K; used for both the
// write and the read address of the FIFO RAM.
module fifo_ptr #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [K-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            // NOTE: clocked state uses <= so every register samples pre-edge values.
            ptr <= ptr + K'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control core: pointers, RAM enables, occupancy count, status and
// sticky error flags around a 1-cycle-latency dual-port RAM.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter bit fwft   = FWFT_ON,
    parameter int K      = K_DEF,
    parameter int AF_LVL = AF_LVL_DEF,
    parameter int AE_LVL = AE_LVL_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_req,
    input  logic         rd_req,
    input  logic         clr_err,
    output logic         ram_we,
    output logic [K-1:0] ram_waddr,
    output logic         ram_re,
    output logic [K-1:0] ram_raddr,
    output logic         dout_valid,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [K:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH   = depth_of(K);
    localparam logic [K:0] DEPTH_V = (K+1)'(DEPTH);
    localparam logic [K:0] AF_V    = (K+1)'(AF_LVL);
    localparam logic [K:0] AE_V    = (K+1)'(AE_LVL);

    logic       push_ok;
    logic       pop_ok;
    logic [K:0] mem_cnt;
    logic [K:0] count_next;
    logic       dout_valid_next;

    // Flags depend only on registered count/dout_valid, never on the requests.
    assign full         = (count == DEPTH_V);
    assign empty        = fwft ? ~dout_valid : (count == '0);
    assign almost_full  = (count >= AF_V);
    assign almost_empty = (count <= AE_V);

    assign ram_we = push_ok;

    always_comb begin
        // NOTE: every signal written here is assigned before any branch, so no latch is inferred.
        push_ok    = wr_req & ~full;
        pop_ok     = rd_req & ~empty;
        mem_cnt    = count - (K+1)'(fwft & dout_valid);
        count_next = count;

        // In FWFT mode the RAM read register is the output stage: refill it
        // whenever it is empty or being drained and RAM still holds words.
        ram_re          = fwft ? ((mem_cnt != '0) & (~dout_valid | pop_ok)) : pop_ok;
        dout_valid_next = fwft ? (ram_re | (dout_valid & ~pop_ok)) : ram_re;

        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + (K+1)'(1);
            2'b01:   count_next = count - (K+1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_next;
            dout_valid <= dout_valid_next;
            // A new error event in the clearing cycle keeps the flag set.
            overflow   <= (wr_req & full)  | (overflow  & ~clr_err);
            underflow  <= (rd_req & empty) | (underflow & ~clr_err);
        end
    end

    fifo_ptr #(.K(K)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (push_ok),
        .ptr   (ram_waddr)
    );

    fifo_ptr #(.K(K)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ram_re),
        .ptr   (ram_raddr)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: one standard-mode and one FWFT-mode instance
// share the request inputs; each phase resets both and checks one of them.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int K = 4;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic wr_req  = 1'b0;
    logic rd_req  = 1'b0;
    logic clr_err = 1'b0;

    logic         s_we, s_re, s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [K-1:0] s_waddr, s_raddr;
    logic [K:0]   s_count;
    logic         f_we, f_re, f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [K-1:0] f_waddr, f_raddr;
    logic [K:0]   f_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_ctrl #(.fwft(FWFT_OFF), .K(K), .AF_LVL(12), .AE_LVL(2)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .ram_we(s_we), .ram_waddr(s_waddr), .ram_re(s_re), .ram_raddr(s_raddr),
        .dout_valid(s_dv), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_ctrl #(.fwft(FWFT_ON), .K(K), .AF_LVL(12), .AE_LVL(2)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .clr_err(clr_err),
        .ram_we(f_we), .ram_waddr(f_waddr), .ram_re(f_re), .ram_raddr(f_raddr),
        .dout_valid(f_dv), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        int wr, rd, clr;
        int we, waddr, re, raddr, dv, cnt, full, empty, af, ae, ovf, unf;
    } vec_t;

    vec_t tv [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's requests at the falling edge, then sample 1 ns later.
    task automatic cyc(input logic w, input logic r, input logic c);
        @(negedge clk);
        wr_req  = w;
        rd_req  = r;
        clr_err = c;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    initial begin
        // Standard mode: fill to full, overflow, clear, pop under a blocked push.
        //            wr rd clr we wa re ra dv cnt fu em af ae ov un
        tv[0]  = '{1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0};
        tv[1]  = '{1, 0, 0,  1, 1, 0, 0, 0,  1, 0, 0, 0, 1, 0, 0};
        tv[2]  = '{1, 0, 0,  1, 2, 0, 0, 0,  2, 0, 0, 0, 1, 0, 0};
        tv[3]  = '{1, 0, 0,  1, 3, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{1, 0, 0,  1, 4, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{1, 0, 0,  1, 5, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{1, 0, 0,  1, 6, 0, 0, 0,  6, 0, 0, 0, 0, 0, 0};
        tv[7]  = '{1, 0, 0,  1, 7, 0, 0, 0,  7, 0, 0, 0, 0, 0, 0};
        tv[8]  = '{1, 0, 0,  1, 8, 0, 0, 0,  8, 0, 0, 0, 0, 0, 0};
        tv[9]  = '{1, 0, 0,  1, 9, 0, 0, 0,  9, 0, 0, 0, 0, 0, 0};
        tv[10] = '{1, 0, 0,  1,10, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0};
        tv[11] = '{1, 0, 0,  1,11, 0, 0, 0, 11, 0, 0, 0, 0, 0, 0};
        tv[12] = '{1, 0, 0,  1,12, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0};
        tv[13] = '{1, 0, 0,  1,13, 0, 0, 0, 13, 0, 0, 1, 0, 0, 0};
        tv[14] = '{1, 0, 0,  1,14, 0, 0, 0, 14, 0, 0, 1, 0, 0, 0};
        tv[15] = '{1, 0, 0,  1,15, 0, 0, 0, 15, 0, 0, 1, 0, 0, 0};
        tv[16] = '{1, 0, 0,  0, 0, 0, 0, 0, 16, 1, 0, 1, 0, 0, 0};
        tv[17] = '{0, 0, 0,  0, 0, 0, 0, 0, 16, 1, 0, 1, 0, 1, 0};
        tv[18] = '{0, 0, 1,  0, 0, 0, 0, 0, 16, 1, 0, 1, 0, 1, 0};
        tv[19] = '{1, 1, 0,  0, 0, 1, 0, 0, 16, 1, 0, 1, 0, 0, 0};
        tv[20] = '{0, 0, 0,  0, 0, 0, 1, 1, 15, 0, 0, 1, 0, 1, 0};
        tv[21] = '{0, 0, 1,  0, 0, 0, 1, 0, 15, 0, 0, 1, 0, 1, 0};
        tv[22] = '{1, 0, 0,  1, 0, 0, 1, 0, 15, 0, 0, 1, 0, 0, 0};
        tv[23] = '{0, 0, 0,  0, 1, 0, 1, 0, 16, 1, 0, 1, 0, 0, 0};

        // Reset state of both instances.
        #12;
        check("rst_std_count", 32'(s_count), 0);
        check("rst_std_empty", 32'(s_empty), 1);
        check("rst_std_full",  32'(s_full),  0);
        check("rst_std_ae",    32'(s_ae),    1);
        check("rst_std_af",    32'(s_af),    0);
        check("rst_fwft_dv",   32'(f_dv),    0);
        check("rst_fwft_empty",32'(f_empty), 1);
        check("rst_fwft_flags",32'({f_ovf, f_unf}), 0);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            cyc(tv[i].wr[0], tv[i].rd[0], tv[i].clr[0]);
            check($sformatf("std%0d_we",    i), 32'(s_we),    tv[i].we);
            check($sformatf("std%0d_waddr", i), 32'(s_waddr), tv[i].waddr);
            check($sformatf("std%0d_re",    i), 32'(s_re),    tv[i].re);
            check($sformatf("std%0d_raddr", i), 32'(s_raddr), tv[i].raddr);
            check($sformatf("std%0d_dv",    i), 32'(s_dv),    tv[i].dv);
            check($sformatf("std%0d_count", i), 32'(s_count), tv[i].cnt);
            check($sformatf("std%0d_full",  i), 32'(s_full),  tv[i].full);
            check($sformatf("std%0d_empty", i), 32'(s_empty), tv[i].empty);
            check($sformatf("std%0d_af",    i), 32'(s_af),    tv[i].af);
            check($sformatf("std%0d_ae",    i), 32'(s_ae),    tv[i].ae);
            check($sformatf("std%0d_ovf",   i), 32'(s_ovf),   tv[i].ovf);
            check($sformatf("std%0d_unf",   i), 32'(s_unf),   tv[i].unf);
        end

        // FWFT single push: read fetch the cycle after, word presented the next.
        do_reset();
        cyc(1, 0, 0);
        check("fw1_push_we",    32'(f_we),    1);
        check("fw1_push_empty", 32'(f_empty), 1);
        cyc(0, 0, 0);
        check("fw1_fetch_re",    32'(f_re),    1);
        check("fw1_fetch_raddr", 32'(f_raddr), 0);
        check("fw1_fetch_dv",    32'(f_dv),    0);
        check("fw1_fetch_count", 32'(f_count), 1);
        cyc(0, 0, 0);
        check("fw1_pres_dv",    32'(f_dv),    1);
        check("fw1_pres_empty", 32'(f_empty), 0);
        check("fw1_pres_re",    32'(f_re),    0);
        check("fw1_pres_count", 32'(f_count), 1);

        // FWFT burst: 8 words queued, then 8 back-to-back pops with no bubble.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            cyc(1, 0, 0);
            check($sformatf("fw8_waddr%0d", j), 32'(f_waddr), 32'(j));
        end
        for (int j = 0; j < 8; j++) begin
            cyc(0, 1, 0);
            check($sformatf("fw8_dv%0d",    j), 32'(f_dv),    1);
            check($sformatf("fw8_empty%0d", j), 32'(f_empty), 0);
            check($sformatf("fw8_count%0d", j), 32'(f_count), 32'(8 - j));
            check($sformatf("fw8_re%0d",    j), 32'(f_re),    32'(j < 7));
            check($sformatf("fw8_raddr%0d", j), 32'(f_raddr), 32'(j + 1));
        end
        cyc(0, 0, 0);
        check("fw8_end_empty", 32'(f_empty), 1);
        check("fw8_end_dv",    32'(f_dv),    0);
        check("fw8_end_count", 32'(f_count), 0);
        check("fw8_end_unf",   32'(f_unf),   0);

        // FWFT steady state at count 5: pointers wrap, flags stay put.
        do_reset();
        for (int j = 0; j < 5; j++) cyc(1, 0, 0);
        for (int j = 0; j < 20; j++) begin
            cyc(1, 1, 0);
            check($sformatf("ss_count%0d", j), 32'(f_count), 5);
            check($sformatf("ss_flags%0d", j), 32'({f_full, f_empty, f_af, f_ae}), 0);
            check($sformatf("ss_dv%0d",    j), 32'(f_dv),    1);
            check($sformatf("ss_we%0d",    j), 32'(f_we),    1);
            check($sformatf("ss_waddr%0d", j), 32'(f_waddr), 32'((5 + j) % 16));
            check($sformatf("ss_re%0d",    j), 32'(f_re),    1);
            check($sformatf("ss_raddr%0d", j), 32'(f_raddr), 32'((1 + j) % 16));
        end
        for (int j = 0; j < 4; j++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("mid_pre_count", 32'(f_count), 9);

        // Asynchronous reset mid-stream, sampled before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(f_count), 0);
        check("mid_rst_empty", 32'(f_empty), 1);
        check("mid_rst_dv",    32'(f_dv),    0);
        check("mid_rst_waddr", 32'(f_waddr), 0);
        check("mid_rst_raddr", 32'(f_raddr), 0);
        check("mid_rst_ae",    32'(f_ae),    1);
        rst_n = 1'b1;

        // Pop on empty, error-vs-clear priority, then push+pop while empty.
        cyc(0, 1, 0);
        check("uf_pre",        32'(f_unf),   0);
        cyc(0, 1, 1);
        check("uf_set",        32'(f_unf),   1);
        check("uf_set_count",  32'(f_count), 0);
        cyc(0, 0, 1);
        check("uf_clr_lost",   32'(f_unf),   1);
        cyc(1, 1, 0);
        check("uf_cleared",    32'(f_unf),   0);
        check("pp_empty_we",   32'(f_we),    1);
        check("pp_empty_re",   32'(f_re),    0);
        cyc(0, 0, 0);
        check("pp_unf",        32'(f_unf),   1);
        check("pp_count",      32'(f_count), 1);
        check("pp_empty",      32'(f_empty), 1);
        check("pp_re",         32'(f_re),    1);
        cyc(0, 0, 0);
        check("pp_dv",         32'(f_dv),    1);
        check("pp_avail",      32'(f_empty), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
